// File: rtl/alu_dispatch_queue_pkg.sv
// Shared RV32I types for the ALU dispatch queue: ALU operation encoding
// and the packed queue-entry layout.
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  // An operand holds a value when its valid flag is set, otherwise a ROB tag
  // in its low bits.
  typedef struct packed {
    logic [31:0] opA;
    logic        v1;
    logic [31:0] opB;
    logic        v2;
    alu_ops      aluop;
  } dq_entry_t;

endpackage

// File: rtl/alu_dispatch_queue_if.sv
// Decode-side enqueue bus and reservation-station dispatch bus of the queue.
interface alu_dispatch_queue_if;

  logic                enq_valid;
  logic                enq_ready;
  logic [31:0]         opA_in;
  logic [31:0]         opB_in;
  logic                v1_in;
  logic                v2_in;
  rv32i_types::alu_ops aluop_in;

  logic                alurs_full;
  logic [31:0]         opA_dec;
  logic [31:0]         opB_dec;
  logic                v1_dec;
  logic                v2_dec;
  rv32i_types::alu_ops aluop_dec;
  logic                load_alurs_dec;

  // Queue side
  modport slave (
    input  enq_valid, opA_in, opB_in, v1_in, v2_in, aluop_in, alurs_full,
    output enq_ready, opA_dec, opB_dec, v1_dec, v2_dec, aluop_dec, load_alurs_dec
  );

  // Decode / reservation-station side
  modport master (
    output enq_valid, opA_in, opB_in, v1_in, v2_in, aluop_in, alurs_full,
    input  enq_ready, opA_dec, opB_dec, v1_dec, v2_dec, aluop_dec, load_alurs_dec
  );

endinterface

// File: rtl/alu_dispatch_queue_operand_resolve.sv
// Resolves one operand against the ROB: an unresolved operand whose tag is
// marked done is replaced by the ROB result and marked valid.
module alu_dq_operand_resolve #(
  parameter int rob_size       = 16,
  parameter int rob_index_bits = 4
) (
  input  logic [31:0]               value_in,
  input  logic                      valid_in,
  input  logic [rob_size-1:0]       done_rob,
  input  logic [rob_size-1:0][31:0] data_rob,
  output logic [31:0]               value_out,
  output logic                      valid_out
);

  logic [rob_index_bits-1:0] tag;

  // Tag lookup: pass through unless the operand waits on a finished ROB entry
  always_comb begin
    tag       = value_in[rob_index_bits-1:0];
    value_out = value_in;
    valid_out = valid_in;
    if (!valid_in && done_rob[tag]) begin
      value_out = data_rob[tag];
      valid_out = 1'b1;
    end
  end

endmodule

// File: rtl/alu_dispatch_queue.sv
// In-order ALU dispatch queue: circular FIFO between decode and the ALU
// reservation station, with ROB result snooping on all stored operands.
module alu_dispatch_queue
  import rv32i_types::*;
#(
  parameter int dq_size        = 4,
  parameter int dq_index_bits  = 2,
  parameter int rob_size       = 16,
  parameter int rob_index_bits = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  alu_dispatch_queue_if.slave       dq,
  input  logic [rob_size-1:0]       done_rob,
  input  logic [rob_size-1:0][31:0] data_rob,
  output logic [dq_index_bits:0]    dq_count,
  output logic [31:0]               stall_cycles
);

  localparam logic [dq_index_bits:0] dq_full = (dq_index_bits+1)'(dq_size);

  dq_entry_t                entries_q [dq_size];
  dq_entry_t                entries_d [dq_size];
  logic [dq_index_bits-1:0] head_q, head_d, tail_q, tail_d;
  logic [dq_index_bits:0]   count_q, count_d;
  logic [31:0]              stall_q, stall_d;

  logic        enq_ready, do_enq, do_deq;
  logic [31:0] enq_opA, enq_opB, head_opA, head_opB;
  logic        enq_v1, enq_v2, head_v1, head_v2;
  logic [31:0] snoop_opA [dq_size];
  logic [31:0] snoop_opB [dq_size];
  logic        snoop_v1  [dq_size];
  logic        snoop_v2  [dq_size];
  dq_entry_t   head_raw;

  assign head_raw = entries_q[head_q];

  // Incoming instruction resolved against results finishing this cycle
  alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_enq_a (
    .value_in(dq.opA_in), .valid_in(dq.v1_in), .done_rob(done_rob), .data_rob(data_rob),
    .value_out(enq_opA), .valid_out(enq_v1));
  alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_enq_b (
    .value_in(dq.opB_in), .valid_in(dq.v2_in), .done_rob(done_rob), .data_rob(data_rob),
    .value_out(enq_opB), .valid_out(enq_v2));

  // Every stored entry snoops the ROB so results are captured at the next edge
  generate
    for (genvar gi = 0; gi < dq_size; gi++) begin : g_snoop
      alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_a (
        .value_in(entries_q[gi].opA), .valid_in(entries_q[gi].v1), .done_rob(done_rob),
        .data_rob(data_rob), .value_out(snoop_opA[gi]), .valid_out(snoop_v1[gi]));
      alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_b (
        .value_in(entries_q[gi].opB), .valid_in(entries_q[gi].v2), .done_rob(done_rob),
        .data_rob(data_rob), .value_out(snoop_opB[gi]), .valid_out(snoop_v2[gi]));
    end
  endgenerate

  // Head entry bypass so a result arriving this cycle is dispatched immediately
  alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_head_a (
    .value_in(head_raw.opA), .valid_in(head_raw.v1), .done_rob(done_rob), .data_rob(data_rob),
    .value_out(head_opA), .valid_out(head_v1));
  alu_dq_operand_resolve #(.rob_size(rob_size), .rob_index_bits(rob_index_bits)) u_head_b (
    .value_in(head_raw.opB), .valid_in(head_raw.v2), .done_rob(done_rob), .data_rob(data_rob),
    .value_out(head_opB), .valid_out(head_v2));

  // Handshakes and head presentation; fields read zero while the queue is empty
  always_comb begin
    enq_ready         = (count_q != dq_full) && !flush;
    do_enq            = dq.enq_valid && enq_ready;
    do_deq            = (count_q != '0) && !dq.alurs_full && !flush;
    dq.enq_ready      = enq_ready;
    dq.load_alurs_dec = do_deq;
    dq.opA_dec        = '0;
    dq.opB_dec        = '0;
    dq.v1_dec         = 1'b0;
    dq.v2_dec         = 1'b0;
    dq.aluop_dec      = alu_add;
    if (count_q != '0) begin
      dq.opA_dec   = head_opA;
      dq.opB_dec   = head_opB;
      dq.v1_dec    = head_v1;
      dq.v2_dec    = head_v2;
      dq.aluop_dec = head_raw.aluop;
    end
  end

  // Next-state: pointer/count bookkeeping, entry writes and stall counter
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    for (int i = 0; i < dq_size; i++) begin
      entries_d[i]      = entries_q[i];
      entries_d[i].opA  = snoop_opA[i];
      entries_d[i].v1   = snoop_v1[i];
      entries_d[i].opB  = snoop_opB[i];
      entries_d[i].v2   = snoop_v2[i];
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) begin
        entries_d[tail_q].opA   = enq_opA;
        entries_d[tail_q].v1    = enq_v1;
        entries_d[tail_q].opB   = enq_opB;
        entries_d[tail_q].v2    = enq_v2;
        entries_d[tail_q].aluop = dq.aluop_in;
        tail_d = tail_q + 1'b1;
      end
      if (do_deq) begin
        head_d = head_q + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if ((count_q != '0) && dq.alurs_full && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
      for (int i = 0; i < dq_size; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      for (int i = 0; i < dq_size; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  assign dq_count     = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_alu_dispatch_queue.sv
// Self-checking bench for alu_dispatch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_dispatch_queue;
  import rv32i_types::*;

  localparam int DQ = 4;
  localparam int RB = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic [RB-1:0]       done_rob = '0;
  logic [RB-1:0][31:0] data_rob = '0;
  logic [2:0]          dq_count;
  logic [31:0]         stall_cycles;

  alu_dispatch_queue_if dq_if ();

  alu_dispatch_queue #(
    .dq_size(DQ), .dq_index_bits(2), .rob_size(RB), .rob_index_bits(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .dq(dq_if),
    .done_rob(done_rob), .data_rob(data_rob),
    .dq_count(dq_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model state
  dq_entry_t   mq[$];
  logic [31:0] m_stall = '0;
  int          checks = 0;
  int          passed = 0;

  function automatic dq_entry_t resolve(input dq_entry_t e);
    dq_entry_t r = e;
    if (!r.v1 && done_rob[r.opA[3:0]]) begin r.opA = data_rob[r.opA[3:0]]; r.v1 = 1'b1; end
    if (!r.v2 && done_rob[r.opB[3:0]]) begin r.opB = data_rob[r.opB[3:0]]; r.v2 = 1'b1; end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic enq(input logic [31:0] a, input logic va, input logic [31:0] b,
                     input logic vb, input alu_ops op);
    dq_if.enq_valid = 1'b1;
    dq_if.opA_in = a; dq_if.v1_in = va;
    dq_if.opB_in = b; dq_if.v2_in = vb;
    dq_if.aluop_in = op;
  endtask

  task automatic idle();
    dq_if.enq_valid = 1'b0;
  endtask

  // One clock: compare outputs at negedge, advance the model at posedge
  task automatic tick(input bit check);
    dq_entry_t h;
    dq_entry_t n;
    int        cnt;
    bit        e_ready, e_load;
    @(negedge clk);
    cnt     = mq.size();
    e_ready = (cnt != DQ) && !flush;
    e_load  = (cnt != 0) && !dq_if.alurs_full && !flush;
    h       = (cnt != 0) ? resolve(mq[0]) : '0;
    if (check) begin
      chk("enq_ready", 32'(dq_if.enq_ready), 32'(e_ready));
      chk("load_alurs_dec", 32'(dq_if.load_alurs_dec), 32'(e_load));
      chk("dq_count", 32'(dq_count), 32'(cnt));
      chk("stall_cycles", stall_cycles, m_stall);
      chk("opA_dec", dq_if.opA_dec, h.opA);
      chk("v1_dec", 32'(dq_if.v1_dec), 32'(h.v1));
      chk("opB_dec", dq_if.opB_dec, h.opB);
      chk("v2_dec", 32'(dq_if.v2_dec), 32'(h.v2));
      chk("aluop_dec", 32'(dq_if.aluop_dec), 32'(h.aluop));
      if (e_load)
        $display("deq opA=%08h v1=%0b opB=%08h v2=%0b aluop=%0d count=%0d",
                 h.opA, h.v1, h.opB, h.v2, h.aluop, cnt);
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_stall = '0;
    end else begin
      if (cnt != 0 && dq_if.alurs_full && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        for (int i = 0; i < mq.size(); i++) mq[i] = resolve(mq[i]);
        if (e_load) void'(mq.pop_front());
        if (dq_if.enq_valid && e_ready) begin
          n.opA = dq_if.opA_in; n.v1 = dq_if.v1_in;
          n.opB = dq_if.opB_in; n.v2 = dq_if.v2_in;
          n.aluop = dq_if.aluop_in;
          mq.push_back(resolve(n));
        end
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    dq_if.enq_valid = 1'b0; dq_if.opA_in = '0; dq_if.opB_in = '0;
    dq_if.v1_in = 1'b0; dq_if.v2_in = 1'b0; dq_if.aluop_in = alu_add;
    dq_if.alurs_full = 1'b0;
    for (int i = 0; i < RB; i++) data_rob[i] = $urandom;

    // Reset, then observe the idle state
    tick(0); tick(0);
    rst = 1'b1;
    tick(1);

    // Single ready instruction passes straight through
    enq(32'd5, 1'b1, 32'd7, 1'b1, alu_add);
    tick(1);
    idle();
    tick(1);
    tick(1);

    // Operand waiting on ROB tag 3 resolved by head bypass, then stored
    dq_if.alurs_full = 1'b1;
    enq(32'd3, 1'b0, 32'd9, 1'b1, alu_sub);
    tick(1);
    idle();
    tick(1);
    tick(1);
    done_rob[3] = 1'b1; data_rob[3] = 32'hDEAD_BEEF;
    tick(1);
    done_rob = '0; data_rob[3] = 32'h0;
    #1;
    chk("stored_resolved_opA", dq_if.opA_dec, 32'hDEAD_BEEF);
    chk("stored_resolved_v1", 32'(dq_if.v1_dec), 32'd1);
    dq_if.alurs_full = 1'b0;
    tick(1);
    tick(1);

    // Fill while blocked: fifth enqueue refused, then drain in order
    dq_if.alurs_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      enq(32'(100 + k), 1'b1, 32'(200 + k), 1'b1, alu_ops'(3'(k)));
      tick(1);
    end
    idle();
    chk("full_count", 32'(dq_count), 32'd4);
    chk("full_enq_ready", 32'(dq_if.enq_ready), 32'd0);
    dq_if.alurs_full = 1'b0;
    for (int k = 0; k < 5; k++) tick(1);

    // Steady state with two entries and simultaneous enqueue/dequeue
    dq_if.alurs_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      enq(32'(300 + k), 1'b1, 32'(400 + k), 1'b1, alu_xor);
      tick(1);
    end
    dq_if.alurs_full = 1'b0;
    for (int k = 2; k < 8; k++) begin
      enq(32'(300 + k), 1'b1, 32'(400 + k), 1'b1, alu_or);
      tick(1);
    end
    idle();
    chk("steady_count", 32'(dq_count), 32'd2);
    for (int k = 0; k < 3; k++) tick(1);

    // Flush with three entries queued and a competing enqueue
    dq_if.alurs_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq(32'(500 + k), 1'b1, 32'(600 + k), 1'b1, alu_and);
      tick(1);
    end
    dq_if.alurs_full = 1'b0;
    flush = 1'b1;
    enq(32'd700, 1'b1, 32'd701, 1'b1, alu_sll);
    tick(1);
    flush = 1'b0;
    idle();
    chk("flush_count", 32'(dq_count), 32'd0);
    chk("flush_opA", dq_if.opA_dec, 32'd0);
    tick(1);

    // Reset mid-operation drops queued entries and the stall counter
    dq_if.alurs_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      enq(32'(800 + k), 1'b1, 32'(900 + k), 1'b1, alu_srl);
      tick(1);
    end
    idle();
    tick(1);
    rst = 1'b0;
    tick(0);
    rst = 1'b1;
    dq_if.alurs_full = 1'b0;
    chk("reset_count", 32'(dq_count), 32'd0);
    chk("reset_stall", stall_cycles, 32'd0);
    chk("reset_load", 32'(dq_if.load_alurs_dec), 32'd0);
    tick(1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 19) == 0);
      dq_if.alurs_full = ($urandom_range(0, 2) == 0);
      dq_if.enq_valid = $urandom_range(0, 1);
      dq_if.opA_in = $urandom; dq_if.v1_in = $urandom_range(0, 1);
      dq_if.opB_in = $urandom; dq_if.v2_in = $urandom_range(0, 1);
      dq_if.aluop_in = alu_ops'(3'($urandom_range(0, 7)));
      done_rob = 16'($urandom & $urandom & $urandom);
      for (int i = 0; i < RB; i++) data_rob[i] = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        tick(0);
        rst = 1'b1;
      end else begin
        tick(1);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
